debounce_ctrl: RTL and testbench



---
 rtl/debounce_ctrl_pkg.sv | 28 ++
 rtl/debounce_ctrl_sync2.sv | 29 ++
 rtl/debounce_ctrl.sv | 146 ++++++++++++++
 tb/tb_debounce_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// debounce_ctrl_pkg
// Shared definitions for the pushbutton debounce / long-press controller:
// FSM state encoding, hold-tick counter width and a helper that derives the
// terminal tick value from the LONG_TICKS parameter.
// -----------------------------------------------------------------------------
package debounce_ctrl_pkg;

    typedef enum logic [1:0] {
        DBNC_IDLE_S   = 2'd0,
        DBNC_SETTLE_S = 2'd1,
        DBNC_HOLD_S   = 2'd2,
        DBNC_LATCH_S  = 2'd3
    } dbnc_state_e;

    localparam int TICK_W = 8;

    // Terminal value of the hold-tick counter. With long_ticks == 0 the
    // hold state is never entered, so the returned value is irrelevant.
    function automatic logic [TICK_W-1:0] last_tick(input int unsigned long_ticks);
        logic [TICK_W-1:0] last;
        last = '0;
        if (long_ticks != 0)
            last = TICK_W'(long_ticks - 1);
        return last;
    endfunction

endpackage

// File: rtl/debounce_ctrl_sync2.sv
// -----------------------------------------------------------------------------
// debounce_ctrl_sync2
// Two-flop synchroniser for a single asynchronous bit, both flops reset to 0.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronised output, lags d by two clock edges
// -----------------------------------------------------------------------------
module debounce_ctrl_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debounce_ctrl.sv
// -----------------------------------------------------------------------------
// debounce_ctrl
// Pushbutton debounce and long-press controller driving a paired timer.
// A level change on the synchronised button starts the timer; the level is
// committed only if it stays stable until the timer expires. A committed
// press then counts LONG_TICKS further timer periods before LONG_PRESS.
// Ports:
//   CLK        - system clock
//   RST_N      - asynchronous active-low reset (shared with the timer)
//   BTN_RAW    - asynchronous raw button input
//   TMR_PULSE  - single-cycle expiry from the paired timer
//   TMR_START  - one-cycle start request to the timer
//   TMR_CLR    - one-cycle abort to the timer
//   BTN_LEVEL  - debounced level, 1 = pressed
//   PRESS      - one-cycle pulse on committed press
//   RELEASE    - one-cycle pulse on committed release
//   LONG_PRESS - one-cycle pulse once per hold
// -----------------------------------------------------------------------------
module debounce_ctrl
    import debounce_ctrl_pkg::*;
#(
    parameter int unsigned ACTIVE_HIGH = 1,
    parameter int unsigned LONG_TICKS  = 8
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN_RAW,
    input  logic TMR_PULSE,
    output logic TMR_START,
    output logic TMR_CLR,
    output logic BTN_LEVEL,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG_PRESS
);

    localparam logic              LONG_EN   = (LONG_TICKS != 0);
    localparam logic [TICK_W-1:0] LAST_TICK = last_tick(LONG_TICKS);

    logic              raw_pol;
    logic              s;
    dbnc_state_e       state, state_nxt;
    logic              target, target_nxt;
    logic [TICK_W-1:0] tick_cnt, tick_nxt;
    logic              level_nxt;
    logic              start_nxt, clr_nxt, press_nxt, release_nxt, long_nxt;

    assign raw_pol = (ACTIVE_HIGH != 0) ? BTN_RAW : ~BTN_RAW;

    debounce_ctrl_sync2 u_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (raw_pol),
        .q     (s)
    );

    always_comb begin
        state_nxt   = state;
        target_nxt  = target;
        tick_nxt    = tick_cnt;
        level_nxt   = BTN_LEVEL;
        start_nxt   = 1'b0;
        clr_nxt     = 1'b0;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;

        case (state)
            DBNC_IDLE_S: begin
                if (s != BTN_LEVEL) begin
                    start_nxt  = 1'b1;
                    target_nxt = s;
                    state_nxt  = DBNC_SETTLE_S;
                end
            end

            DBNC_SETTLE_S: begin
                // A bounce takes priority over a coincident expiry.
                if (s != target) begin
                    clr_nxt   = 1'b1;
                    state_nxt = DBNC_IDLE_S;
                end else if (TMR_PULSE) begin
                    level_nxt   = target;
                    press_nxt   = target;
                    release_nxt = ~target;
                    if (target && LONG_EN) begin
                        tick_nxt  = '0;
                        start_nxt = 1'b1;
                        state_nxt = DBNC_HOLD_S;
                    end else begin
                        state_nxt = DBNC_IDLE_S;
                    end
                end
            end

            DBNC_HOLD_S: begin
                // Release takes priority over a coincident expiry; the
                // release itself is debounced from IDLE.
                if (!s) begin
                    clr_nxt   = 1'b1;
                    state_nxt = DBNC_IDLE_S;
                end else if (TMR_PULSE) begin
                    if (tick_cnt == LAST_TICK) begin
                        long_nxt  = 1'b1;
                        state_nxt = DBNC_LATCH_S;
                    end else begin
                        tick_nxt  = tick_cnt + 1'b1;
                        start_nxt = 1'b1;
                    end
                end
            end

            DBNC_LATCH_S: begin
                if (!s)
                    state_nxt = DBNC_IDLE_S;
            end

            default: state_nxt = DBNC_IDLE_S;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= DBNC_IDLE_S;
            target     <= 1'b0;
            tick_cnt   <= '0;
            BTN_LEVEL  <= 1'b0;
            TMR_START  <= 1'b0;
            TMR_CLR    <= 1'b0;
            PRESS      <= 1'b0;
            RELEASE    <= 1'b0;
            LONG_PRESS <= 1'b0;
        end else begin
            state      <= state_nxt;
            target     <= target_nxt;
            tick_cnt   <= tick_nxt;
            BTN_LEVEL  <= level_nxt;
            TMR_START  <= start_nxt;
            TMR_CLR    <= clr_nxt;
            PRESS      <= press_nxt;
            RELEASE    <= release_nxt;
            LONG_PRESS <= long_nxt;
        end
    end

endmodule

// File: tb/tb_debounce_ctrl.sv
// -----------------------------------------------------------------------------
// tb_debounce_ctrl
// Directed bench for debounce_ctrl. Instance a: active-high button,
// LONG_TICKS=3. Instance b: active-low button, LONG_TICKS=0. The timer
// expiry is driven directly by the bench so that expiry timing can be
// placed on exact cycles. Output vector per instance is
// {TMR_START, TMR_CLR, BTN_LEVEL, PRESS, RELEASE, LONG_PRESS}.
// -----------------------------------------------------------------------------
module tb_debounce_ctrl;

    localparam logic [5:0] O_Z   = 6'b000000; // nothing
    localparam logic [5:0] O_L   = 6'b001000; // level held
    localparam logic [5:0] O_ST  = 6'b100000; // start, level 0
    localparam logic [5:0] O_STL = 6'b101000; // start, level 1
    localparam logic [5:0] O_CL  = 6'b010000; // clear, level 0
    localparam logic [5:0] O_CLL = 6'b011000; // clear, level 1
    localparam logic [5:0] O_PRS = 6'b101100; // press + hold start
    localparam logic [5:0] O_PR  = 6'b001100; // press, no hold
    localparam logic [5:0] O_RL  = 6'b000010; // release
    localparam logic [5:0] O_LP  = 6'b001001; // long press

    logic clk;
    logic rst_n;
    logic raw_a, pulse_a, start_a, clr_a, lvl_a, press_a, rel_a, lp_a;
    logic raw_b, pulse_b, start_b, clr_b, lvl_b, press_b, rel_b, lp_b;
    logic [5:0] outs_a, outs_b;

    int n_checks = 0;
    int n_fail   = 0;

    assign outs_a = {start_a, clr_a, lvl_a, press_a, rel_a, lp_a};
    assign outs_b = {start_b, clr_b, lvl_b, press_b, rel_b, lp_b};

    debounce_ctrl #(.ACTIVE_HIGH(1), .LONG_TICKS(3)) u_dut_a (
        .CLK        (clk),
        .RST_N      (rst_n),
        .BTN_RAW    (raw_a),
        .TMR_PULSE  (pulse_a),
        .TMR_START  (start_a),
        .TMR_CLR    (clr_a),
        .BTN_LEVEL  (lvl_a),
        .PRESS      (press_a),
        .RELEASE    (rel_a),
        .LONG_PRESS (lp_a)
    );

    debounce_ctrl #(.ACTIVE_HIGH(0), .LONG_TICKS(0)) u_dut_b (
        .CLK        (clk),
        .RST_N      (rst_n),
        .BTN_RAW    (raw_b),
        .TMR_PULSE  (pulse_b),
        .TMR_START  (start_b),
        .TMR_CLR    (clr_b),
        .BTN_LEVEL  (lvl_b),
        .PRESS      (press_b),
        .RELEASE    (rel_b),
        .LONG_PRESS (lp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed a=%b b=%b, expected a=%b b=%b",
                     tag, obs[11:6], obs[5:0], exp[11:6], exp[5:0]);
        end
    endtask

    // Advance one clock, then compare both instances' outputs.
    task automatic step(input string tag, input logic [5:0] exp_a, input logic [5:0] exp_b);
        @(posedge clk);
        #1;
        check_eq(tag, {outs_a, outs_b}, {exp_a, exp_b});
    endtask

    // Wait gap cycles, then present a one-cycle timer expiry to a or b.
    task automatic wait_fire(input string tag, input int gap,
                             input logic [5:0] idle_a, input logic [5:0] fire_a,
                             input logic [5:0] idle_b, input logic [5:0] fire_b,
                             input bit on_b);
        for (int i = 0; i < gap; i++)
            step(tag, idle_a, idle_b);
        if (on_b) pulse_b = 1'b1;
        else      pulse_a = 1'b1;
        step(tag, fire_a, fire_b);
        pulse_a = 1'b0;
        pulse_b = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        raw_a   = 1'b0;
        pulse_a = 1'b0;
        raw_b   = 1'b1;  // active-low button released
        pulse_b = 1'b0;

        // Reset state
        step("rst0", O_Z, O_Z);
        step("rst1", O_Z, O_Z);
        rst_n = 1'b1;

        // Clean press, commit enters hold with LONG_TICKS=3
        raw_a = 1'b1;
        step("cp_sync1", O_Z, O_Z);
        step("cp_sync2", O_Z, O_Z);
        step("cp_start", O_ST, O_Z);
        wait_fire("cp_commit", 2, O_Z, O_PRS, O_Z, O_Z, 0);
        step("cp_after", O_L, O_Z);

        // Long press: two restarts, then LONG_PRESS, then silence in latch
        wait_fire("lp_tick1", 2, O_L, O_STL, O_Z, O_Z, 0);
        wait_fire("lp_tick2", 2, O_L, O_STL, O_Z, O_Z, 0);
        wait_fire("lp_fire", 2, O_L, O_LP, O_Z, O_Z, 0);
        wait_fire("latch_spur", 2, O_L, O_L, O_Z, O_Z, 0);
        step("latch_hold", O_L, O_Z);

        // Release from latch, debounced through idle
        raw_a = 1'b0;
        step("rl_sync1", O_L, O_Z);
        step("rl_sync2", O_L, O_Z);
        step("rl_exit", O_L, O_Z);
        step("rl_start", O_STL, O_Z);
        wait_fire("rl_commit", 2, O_L, O_RL, O_Z, O_Z, 0);
        step("rl_after", O_Z, O_Z);

        // Bounce 1,0,1 then hold
        raw_a = 1'b1;
        step("bn_1", O_Z, O_Z);
        raw_a = 1'b0;
        step("bn_2", O_Z, O_Z);
        raw_a = 1'b1;
        step("bn_start1", O_ST, O_Z);
        step("bn_clr", O_CL, O_Z);
        step("bn_start2", O_ST, O_Z);
        wait_fire("bn_commit", 2, O_Z, O_PRS, O_Z, O_Z, 0);
        step("bn_after", O_L, O_Z);

        // Early release in hold at tick 1
        wait_fire("er_tick1", 2, O_L, O_STL, O_Z, O_Z, 0);
        raw_a = 1'b0;
        step("er_sync1", O_L, O_Z);
        step("er_sync2", O_L, O_Z);
        step("er_clr", O_CLL, O_Z);
        step("er_start", O_STL, O_Z);
        wait_fire("er_commit", 2, O_L, O_RL, O_Z, O_Z, 0);
        step("er_after", O_Z, O_Z);

        // Bounce coincident with expiry in settle
        raw_a = 1'b1;
        step("ss_sync1", O_Z, O_Z);
        step("ss_sync2", O_Z, O_Z);
        step("ss_start", O_ST, O_Z);
        raw_a = 1'b0;
        step("ss_w1", O_Z, O_Z);
        step("ss_w2", O_Z, O_Z);
        pulse_a = 1'b1;
        step("ss_bounce_wins", O_CL, O_Z);
        pulse_a = 1'b0;
        step("ss_idle1", O_Z, O_Z);
        step("ss_idle2", O_Z, O_Z);

        // Release coincident with expiry in hold
        raw_a = 1'b1;
        step("sh_sync1", O_Z, O_Z);
        step("sh_sync2", O_Z, O_Z);
        step("sh_start", O_ST, O_Z);
        wait_fire("sh_commit", 2, O_Z, O_PRS, O_Z, O_Z, 0);
        wait_fire("sh_tick1", 2, O_L, O_STL, O_Z, O_Z, 0);
        raw_a = 1'b0;
        step("sh_sync3", O_L, O_Z);
        step("sh_sync4", O_L, O_Z);
        pulse_a = 1'b1;
        step("sh_release_wins", O_CLL, O_Z);
        pulse_a = 1'b0;
        step("sh_rstart", O_STL, O_Z);
        wait_fire("sh_rcommit", 2, O_L, O_RL, O_Z, O_Z, 0);
        step("sh_after", O_Z, O_Z);

        // Reset mid-settle with the button held
        raw_a = 1'b1;
        step("rs_sync1", O_Z, O_Z);
        step("rs_sync2", O_Z, O_Z);
        step("rs_start", O_ST, O_Z);
        rst_n = 1'b0;
        #1;
        check_eq("rs_async", {outs_a, outs_b}, {O_Z, O_Z});
        step("rs_hold1", O_Z, O_Z);
        step("rs_hold2", O_Z, O_Z);
        rst_n = 1'b1;
        step("rs_sync3", O_Z, O_Z);
        step("rs_sync4", O_Z, O_Z);
        step("rs_start2", O_ST, O_Z);
        wait_fire("rs_commit", 2, O_Z, O_PRS, O_Z, O_Z, 0);
        step("rs_no_release", O_L, O_Z);
        raw_a = 1'b0;
        step("rs_sync5", O_L, O_Z);
        step("rs_sync6", O_L, O_Z);
        step("rs_clr", O_CLL, O_Z);
        step("rs_rstart", O_STL, O_Z);
        wait_fire("rs_rcommit", 2, O_L, O_RL, O_Z, O_Z, 0);
        step("rs_after", O_Z, O_Z);

        // Active-low instance, long-press disabled
        raw_b = 1'b0;
        step("b_sync1", O_Z, O_Z);
        step("b_sync2", O_Z, O_Z);
        step("b_start", O_Z, O_ST);
        wait_fire("b_commit", 2, O_Z, O_Z, O_Z, O_PR, 1);
        step("b_after", O_Z, O_L);
        wait_fire("b_spur", 2, O_Z, O_Z, O_L, O_L, 1);
        raw_b = 1'b1;
        step("b_sync3", O_Z, O_L);
        step("b_sync4", O_Z, O_L);
        step("b_rstart", O_Z, O_STL);
        wait_fire("b_rcommit", 2, O_Z, O_Z, O_L, O_RL, 1);
        step("b_end", O_Z, O_Z);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
